// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: busy scoreboard plus round-robin writeback arbiter
// feeding the single register file write port through a one-deep write stage.
// Optional macro REGFILE_WB_BYPASS_EN adds query-port forwarding from the
// write stage (o_q_fwd_valid / o_q_fwd_data) and masks o_q_busy on a hit.
module regfile_wb_scheduler #(
  parameter int N_REQ      = 3,
  parameter int N_REGS     = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_QPORTS   = 2,
  localparam int AW        = $clog2(N_REGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rsv_valid,
  input  logic [AW-1:0]         i_rsv_addr,
  output logic                  o_rsv_ready,
  input  logic [N_REQ-1:0]      i_wb_valid,
  input  logic [AW-1:0]         i_wb_addr [N_REQ],
  input  logic [DATA_WIDTH-1:0] i_wb_data [N_REQ],
  output logic [N_REQ-1:0]      o_wb_ready,
  output logic                  o_rf_we,
  output logic [AW-1:0]         o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  input  logic [AW-1:0]         i_q_addr [N_QPORTS],
  output logic [N_QPORTS-1:0]   o_q_busy,
  output logic [N_REGS-1:0]     o_busy_vec,
  output logic                  o_wb_err
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic [N_QPORTS-1:0]   o_q_fwd_valid,
  output logic [DATA_WIDTH-1:0] o_q_fwd_data [N_QPORTS]
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REGS-1:0]     busy;
  logic [N_REGS-1:0]     busy_next;
  logic [PW-1:0]         ptr;
  logic                  rsv_fire;
  logic                  gnt_any;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         cand;
  logic [AW-1:0]         gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;

  assign o_busy_vec = busy;

  // Reservation handshake: accept only when the destination has no pending write.
  always_comb begin
    o_rsv_ready = !i_rst && !busy[i_rsv_addr];
    rsv_fire    = o_rsv_ready && i_rsv_valid && (i_rsv_addr != '0);
  end

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    o_wb_ready = '0;
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_addr   = '0;
    gnt_data   = '0;
    cand       = '0;
    if (!i_rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cand = PW'((32'(ptr) + i) % N_REQ);
        if (!gnt_any && i_wb_valid[cand]) begin
          gnt_any          = 1'b1;
          gnt_idx          = cand;
          gnt_addr         = i_wb_addr[cand];
          gnt_data         = i_wb_data[cand];
          o_wb_ready[cand] = 1'b1;
        end
      end
    end
  end

  // Scoreboard update: clear the register being written this edge, set the new
  // reservation. They never collide because a busy register refuses reservation.
  always_comb begin
    busy_next = busy;
    if (o_rf_we) busy_next[o_rf_waddr] = 1'b0;
    if (rsv_fire) busy_next[i_rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // State: scoreboard, arbitration pointer, write stage and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy       <= '0;
      ptr        <= '0;
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
      o_wb_err   <= 1'b0;
    end else begin
      busy <= busy_next;
      if (gnt_any) begin
        o_rf_we    <= (gnt_addr != '0);
        o_rf_waddr <= gnt_addr;
        o_rf_wdata <= gnt_data;
        ptr        <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        if ((gnt_addr != '0) && !busy[gnt_addr]) o_wb_err <= 1'b1;
      end else begin
        o_rf_we <= 1'b0;
      end
    end
  end

  // Busy queries for issue-stage hazard checks (optionally forwarded from the write stage).
  always_comb begin
    o_q_busy = '0;
`ifdef REGFILE_WB_BYPASS_EN
    o_q_fwd_valid = '0;
    for (int unsigned j = 0; j < N_QPORTS; j++) begin
      o_q_fwd_valid[j] = o_rf_we && (o_rf_waddr == i_q_addr[j]) && (i_q_addr[j] != '0);
      o_q_fwd_data[j]  = o_rf_wdata;
      o_q_busy[j]      = busy[i_q_addr[j]] && !o_q_fwd_valid[j];
    end
`else
    for (int unsigned j = 0; j < N_QPORTS; j++) begin
      o_q_busy[j] = busy[i_q_addr[j]];
    end
`endif
  end

endmodule
